mult_seq: RTL

Iterative shift-add multiplier sequencer for the MIPS datapath. It computes the 64-bit HI/LO product of two 32-bit operands over a fixed number of cycles, using one shared adder step per cycle. It covers the multiply operation that the single-cycle ALU does not implement. It sits beside the ALU in the execute stage, and the control unit stalls on `busy` until `done`.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/mult_seq_if.sv | 24 ++
 rtl/mult_step.sv | 18 +
 rtl/mult_seq.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the multiplier sequencer states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_SUMA  = 4'd0,
      OP_RESTA = 4'd1,
      OP_ABS   = 4'd2,
      OP_IGUAL = 4'd3,
      OP_AND   = 4'd4,
      OP_OR    = 4'd5,
      OP_XOR   = 4'd6,
      OP_SLT   = 4'd7,
      OP_MULT  = 4'd8
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mult_state_t;

endpackage

// File: rtl/mult_seq_if.sv
// Request/response bundle between the execute-stage control and mult_seq.
interface mult_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, signed_op, a, b,
      input  ready, busy, done, hi, lo
   );

   modport slave (
      input  start, signed_op, a, b,
      output ready, busy, done, hi, lo
   );
endinterface

// File: rtl/mult_step.sv
// One shift-add iteration: conditional add of M into hi, then shift {carry,hi,lo} right.
module mult_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] hi_n,
   output logic [WIDTH-1:0] lo_n
);
   logic [WIDTH:0] sum;

   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
   end
endmodule

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier; signed support (magnitude in, FIX negate out)
// is built only when MULT_SIGNED_EN is defined.
module mult_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic       clk,
   input logic       rst,
   mult_seq_if.slave bus
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   mult_state_t      state_q;
   mult_state_t      state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] hi_n;
   logic [WIDTH-1:0] lo_n;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

`ifdef MULT_SIGNED_EN
   logic             neg_q;
   logic             neg_d;
   logic [2*WIDTH-1:0] fix_v;

   // 0x80.. negates to itself, which read as unsigned is the right magnitude
   always_comb begin
      a_mag = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      neg_d = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      fix_v = -{hi_q, lo_q};
   end
`else
   logic unused_signed_op;

   assign unused_signed_op = bus.signed_op;
   assign a_mag            = bus.a;
   assign b_mag            = bus.b;
`endif

   mult_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .hi   (hi_q),
      .lo   (lo_q),
      .m    (m_q),
      .hi_n (hi_n),
      .lo_n (lo_n)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MULT_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  m_q   <= a_mag;
                  hi_q  <= '0;
                  lo_q  <= b_mag;
                  cnt_q <= '0;
`ifdef MULT_SIGNED_EN
                  neg_q <= neg_d;
`endif
               end
            end
            RUN: begin
               hi_q  <= hi_n;
               lo_q  <= lo_n;
               cnt_q <= cnt_q + CNT_W'(1);
            end
`ifdef MULT_SIGNED_EN
            FIX: begin
               {hi_q, lo_q} <= fix_v;
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) state_d = RUN;
         end
         RUN: begin
            if (cnt_q == LAST) begin
`ifdef MULT_SIGNED_EN
               state_d = neg_q ? FIX : DONE;
`else
               state_d = DONE;
`endif
            end
         end
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.ready = (state_q == IDLE);
   assign bus.busy  = (state_q == RUN) || (state_q == FIX);
   assign bus.done  = (state_q == DONE);
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
endmodule
